// File: rtl/mdio_ctrl.sv
// MDIO management sequencer: soft-resets the PHY, then periodically polls
// BMSR and the PHY-specific status register to publish link state and speed.
module mdio_ctrl #(
  parameter logic [23:0] POLL_CNT  = 24'd250_000,
  parameter logic [4:0]  SPEC_REG  = 5'h11,
  parameter logic [15:0] BMCR_INIT = 16'h9140
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        soft_rst_trig,
  output logic        op_exec,
  output logic        op_rh_wl,
  output logic [4:0]  op_addr,
  output logic [15:0] op_wr_data,
  input  logic        op_done,
  input  logic [15:0] op_rd_data,
  input  logic        op_rd_ack,
  output logic        link_up,
  output logic [1:0]  speed,
  output logic        phy_err
);

  typedef enum logic [2:0] {RST_WR, RST_POLL, WAIT, RD_BMSR, RD_SPEC} state_e;

  state_e      state_q, state_d;
  logic        wait_ph_q, wait_ph_d;  // 0 = issue sub-phase, 1 = awaiting op_done
  logic [23:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        exec_q, exec_d;
  logic        rh_q, rh_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        link_q, link_d;
  logic [1:0]  speed_q, speed_d;
  logic        err_q, err_d;

  logic issue, done, cnt_last, unused_rd;

  assign issue     = (state_q != WAIT) && !wait_ph_q;
  assign done      = (state_q != WAIT) && wait_ph_q && op_done;
  assign cnt_last  = ({1'b0, cnt_q} + 25'd1) >= {1'b0, POLL_CNT};
  assign unused_rd = ^{op_rd_data[13:3], op_rd_data[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_WR;
      wait_ph_q <= 1'b0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      exec_q    <= 1'b0;
      rh_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      link_q    <= 1'b0;
      speed_q   <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_ph_q <= wait_ph_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      exec_q    <= exec_d;
      rh_q      <= rh_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      link_q    <= link_d;
      speed_q   <= speed_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_ph_d = wait_ph_q;
    if (state_q == WAIT) begin
      wait_ph_d = 1'b0;
      if (pend_q)        state_d = RST_WR;
      else if (cnt_last) state_d = RD_BMSR;
    end else if (issue) begin
      wait_ph_d = 1'b1;
    end else if (done) begin
      wait_ph_d = 1'b0;
      case (state_q)
        RST_WR:   state_d = RST_POLL;
        RST_POLL: if (op_rd_ack || !op_rd_data[15]) state_d = WAIT;
        RD_BMSR:  state_d = (op_rd_ack || !op_rd_data[2]) ? WAIT : RD_SPEC;
        RD_SPEC:  state_d = WAIT;
        default:  state_d = RST_WR;
      endcase
    end
  end

  always_comb begin
    exec_d  = 1'b0;
    rh_d    = rh_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    link_d  = link_q;
    speed_d = speed_q;
    err_d   = err_q;
    cnt_d   = '0;
    pend_d  = pend_q | soft_rst_trig;

    if (issue) begin
      exec_d  = 1'b1;
      rh_d    = 1'b1;
      wdata_d = '0;
      case (state_q)
        RST_WR: begin
          rh_d    = 1'b0;
          addr_d  = 5'd0;
          wdata_d = BMCR_INIT;
        end
        RST_POLL: addr_d = 5'd0;
        RD_BMSR:  addr_d = 5'd1;
        default:  addr_d = SPEC_REG;
      endcase
    end

    if (done) begin
      case (state_q)
        RST_POLL: if (op_rd_ack) err_d = 1'b1;
        RD_BMSR: begin
          if (op_rd_ack) err_d = 1'b1;
          if (op_rd_ack || !op_rd_data[2]) link_d = 1'b0;
        end
        RD_SPEC: begin
          if (op_rd_ack) begin
            err_d  = 1'b1;
            link_d = 1'b0;
          end else if (op_rd_data[15:14] == 2'b11) begin
            link_d = 1'b0;
          end else begin
            speed_d = op_rd_data[15:14];
            link_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A trigger landing in the consuming cycle folds into the reset being started.
    if (state_q == WAIT) begin
      if (pend_q) begin
        pend_d = 1'b0;
        err_d  = 1'b0;
      end else if (!cnt_last) begin
        cnt_d = cnt_q + 24'd1;
      end
    end
  end

  assign op_exec    = exec_q;
  assign op_rh_wl   = rh_q;
  assign op_addr    = addr_q;
  assign op_wr_data = wdata_q;
  assign link_up    = link_q;
  assign speed      = speed_q;
  assign phy_err    = err_q;

endmodule
